// File: rtl/atan_fixed_pkg.sv
// Shared fixed-point definitions for the arctangent datapath.
//   ATAN_FRAC    : fractional bits of the Q1.x ratio fed to the polynomial
//   ONE_Q14      : 1.0 in Q1.14
//   atan_state_e : control states of the ratio divider
//   atan_flags_t : octant flag bundle handed to the quadrant-correction stage
package atan_fixed_pkg;

  localparam int ATAN_FRAC = 14;
  localparam logic signed [15:0] ONE_Q14 = 16'sd16384;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } atan_state_e;

  typedef struct packed {
    logic swap;     // |num| > |den|, ratio is |den|/|num|
    logic num_neg;  // num < 0
    logic den_neg;  // den < 0
    logic zero;     // both inputs zero, ratio forced to 0
  } atan_flags_t;

endpackage

// File: rtl/atan_div_step.sv
// One combinational restoring-division iteration.
//   rem      : partial remainder (DW+1 bits; always < 2*div on entry)
//   div      : divisor magnitude (DW bits)
//   rem_next : remainder after the conditional subtract, shifted left by one
//   qbit     : quotient bit produced by this iteration
module atan_div_step #(
  parameter int DW = 17
) (
  input  logic [DW:0]   rem,
  input  logic [DW-1:0] div,
  output logic [DW:0]   rem_next,
  output logic          qbit
);

  logic [DW-1:0] kept;

  // When the subtract is taken the difference is below div, so the
  // low DW bits hold it exactly and the shift cannot overflow DW+1 bits.
  always_comb begin
    qbit     = (rem >= {1'b0, div});
    kept     = qbit ? (rem[DW-1:0] - div) : rem[DW-1:0];
    rem_next = {kept, 1'b0};
  end

endmodule

// File: rtl/atan_ratio_div.sv
// Argument reduction for the Q1.14 arctangent: ratio = min(|num|,|den|) /
// max(|num|,|den|) via a sequential restoring divider, plus octant flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake for the (num, den) pair
//   num, den             : signed W-bit samples
//   out_valid/out_ready  : output handshake
//   ratio                : Q1.FRAC quotient in [0, 1.0], zero-extended to 16 bits
//   swap, num_neg, den_neg, zero : octant flags for the result
module atan_ratio_div
  import atan_fixed_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = ATAN_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [15:0]  ratio,
  output logic                swap,
  output logic                num_neg,
  output logic                den_neg,
  output logic                zero
);

  localparam int QBITS = FRAC + 1;
  localparam int CW    = $clog2(QBITS + 1);
  localparam int MW    = W + 1;

  atan_state_e   state, state_nx;
  logic          armed;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [MW:0]   rem, rem_nx;
  logic [MW-1:0] dvr;
  logic [QBITS-1:0] q;
  logic          qbit;
  logic [15:0]   ratio_r;
  atan_flags_t   flags_r, flags_out;

  logic [MW-1:0] mag_n, mag_d, mag_max, mag_min;
  logic          in_swap;

  always_comb begin
    mag_n   = num[W-1] ? ({1'b0, ~num} + MW'(1)) : {1'b0, num};
    mag_d   = den[W-1] ? ({1'b0, ~den} + MW'(1)) : {1'b0, den};
    in_swap = (mag_n > mag_d);
    mag_max = in_swap ? mag_n : mag_d;
    mag_min = in_swap ? mag_d : mag_n;
  end

  atan_div_step #(.DW(MW)) u_step (
    .rem      (rem),
    .div      (dvr),
    .rem_next (rem_nx),
    .qbit     (qbit)
  );

  // in_ready is held low until the first edge after reset release.
  assign in_ready  = armed && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_DIV;
      ST_DIV:  if (cnt == CW'(QBITS)) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // DIV spends QBITS cycles producing bits, then one more cycle
  // registering the result so outputs stay frozen throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem       <= '0;
      dvr       <= '0;
      q         <= '0;
      flags_r   <= '0;
      ratio_r   <= '0;
      flags_out <= '0;
    end else if (accept) begin
      cnt     <= '0;
      rem     <= {1'b0, mag_min};
      dvr     <= mag_max;
      q       <= '0;
      flags_r <= '{swap: in_swap, num_neg: num[W-1], den_neg: den[W-1],
                   zero: (mag_max == '0)};
    end else if (state == ST_DIV) begin
      if (cnt != CW'(QBITS)) begin
        rem <= rem_nx;
        q   <= {q[QBITS-2:0], qbit};
        cnt <= cnt + CW'(1);
      end else begin
        ratio_r   <= flags_r.zero ? '0 : 16'(q);
        flags_out <= flags_r;
      end
    end
  end

  assign ratio   = ratio_r;
  assign swap    = flags_out.swap;
  assign num_neg = flags_out.num_neg;
  assign den_neg = flags_out.den_neg;
  assign zero    = flags_out.zero;

endmodule

// File: tb/tb_atan_ratio_div.sv
module tb_atan_ratio_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [15:0] num = '0;
  logic signed [15:0] den = '0;
  logic in_ready, out_valid, swap, num_neg, den_neg, zero;
  logic signed [15:0] ratio;

  atan_ratio_div #(.W(16), .FRAC(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ratio     (ratio),
    .swap      (swap),
    .num_neg   (num_neg),
    .den_neg   (den_neg),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint ratio;
    bit swap, nn, dn, z;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: floor(min*16384/max) on true magnitudes, flags from signs.
  function automatic exp_t model(input logic signed [15:0] n, input logic signed [15:0] d);
    exp_t r;
    longint an, ad, mx, mn;
    an = (n < 0) ? -longint'(n) : longint'(n);
    ad = (d < 0) ? -longint'(d) : longint'(d);
    r.swap = an > ad;
    mx = r.swap ? an : ad;
    mn = r.swap ? ad : an;
    r.z = (mx == 0);
    r.ratio = (mx == 0) ? 0 : (mn * 16384) / mx;
    r.nn = n < 0;
    r.dn = d < 0;
    return r;
  endfunction

  // Compare process: scoreboard + hold-stability checks at the falling edge.
  bit hold = 0;
  logic [19:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      hold = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_stable", {ratio, swap, num_neg, den_neg, zero}, held);
      end
      if (out_valid) begin
        chk("ratio_range", (ratio >= 0 && ratio <= 16384), 1);
        if (sbq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sbq[0];
          chk("sb_ratio", ratio, e.ratio);
          chk("sb_flags", {swap, num_neg, den_neg, zero}, {e.swap, e.nn, e.dn, e.z});
          if (out_ready) void'(sbq.pop_front());
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(num, den));
      hold = out_valid && !out_ready;
      held = {ratio, swap, num_neg, den_neg, zero};
    end
  end

  task automatic send(input logic signed [15:0] n, input logic signed [15:0] d);
    int t = 0;
    num = n;
    den = d;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic run_vec(input string nm, input logic signed [15:0] n, input logic signed [15:0] d,
                         input int er, input bit es, input bit enn, input bit edn, input bit ez,
                         input bit lat);
    int cyc;
    send(n, d);
    wait_out(cyc);
    if (lat) chk({nm, "_latency"}, cyc, 16);
    chk({nm, "_ratio"}, ratio, er);
    chk({nm, "_flags"}, {swap, num_neg, den_neg, zero}, {es, enn, edn, ez});
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    logic signed [15:0] rn, rd;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ratio", ratio, 0);
    chk("rst_flags", {swap, num_neg, den_neg, zero}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", in_ready, 1);

    // Directed vectors
    run_vec("v1", 16'sd1000, 16'sd2000, 8192, 0, 0, 0, 0, 1);
    run_vec("v2", -16'sd3000, 16'sd1000, 5461, 1, 1, 0, 0, 1);
    run_vec("v3", -16'sd32768, -16'sd32768, 16384, 0, 1, 1, 0, 0);
    run_vec("v4a", 16'sd0, 16'sd0, 0, 0, 0, 0, 1, 1);
    run_vec("v4b", 16'sd0, -16'sd5, 0, 0, 0, 1, 0, 0);
    run_vec("v_max", 16'sd32767, -16'sd32768, 16383, 0, 0, 1, 0, 0);
    run_vec("v_mnz", -16'sd32768, 16'sd0, 0, 1, 1, 0, 0, 0);

    // Backpressure
    out_ready = 1'b0;
    send(16'sd100, 16'sd300);
    wait_out(cyc);
    num = 16'sd555;
    den = 16'sd111;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_ratio", ratio, 5461);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_done_no_accept", in_ready, 0);
    @(posedge clk); #1;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_nvalid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(cyc);
    chk("bp2_ratio", ratio, 3276);
    chk("bp2_flags", {swap, num_neg, den_neg, zero}, 4'b1000);
    @(posedge clk); #1;

    // Reset on the 7th DIV cycle
    send(16'sd1234, 16'sd4321);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready_low", in_ready, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("no_stale_result", seen, 0);
    run_vec("v7", 16'sd7, 16'sd7, 16384, 0, 0, 0, 0, 1);

    // Sweep against the model
    for (int i = 0; i < 40; i++) begin
      rn = 16'($urandom);
      rd = 16'($urandom);
      if (i % 4 == 1) rd = 16'($urandom_range(0, 200)) - 16'sd100;
      if (i % 8 == 3) rd = rn;
      if (i % 8 == 5) rd = -rn;
      send(rn, rd);
      wait_out(cyc);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
